fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL signal an instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL carry the word-aligned fetch address.
REQ-006 imem_gnt  input  1  SHALL indicate acceptance of the request in the current cycle.
REQ-007 imem_rvalid  input  1  SHALL qualify imem_rdata, one cycle or more after grant.
REQ-008 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-009 inst  output  32  SHALL carry the held instruction to decode/immgen.
REQ-010 pcvalue  output  32  SHALL carry the address of inst.
REQ-011 inst_valid  output  1  SHALL mark inst/pcvalue as valid.
REQ-012 stall  input  1  SHALL hold the current instruction when high.
REQ-013 redirect_en  input  1  SHALL select redirect_pc as the next fetch address.
REQ-014 redirect_pc  input  32  SHALL carry the taken jal/branch/jalr target.
REQ-015 fetch_misalign  output  1  SHALL flag a misaligned redirect target (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD, HALT.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 REQ: imem_req=1, imem_addr=fetch_pc; on imem_gnt go to WAIT; imem_addr SHALL stay stable while imem_req && !imem_gnt.
REQ-019 WAIT: imem_req=0; on imem_rvalid latch inst=imem_rdata, pcvalue=fetch_pc, inst_valid=1, go to HOLD.
REQ-020 HOLD: inst, pcvalue, inst_valid=1 SHALL be held while stall=1.
REQ-021 HOLD with stall=0 (consume): next fetch_pc = redirect_en ? redirect_pc : pcvalue+32'd4; inst_valid=0 next cycle; go to REQ.
REQ-022 redirect_en SHALL be ignored unless inst_valid && !stall.
REQ-023 pcvalue+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 imem_rvalid outside WAIT SHALL be ignored; imem_gnt outside REQ SHALL be ignored.
REQ-025 Minimum throughput SHALL be one instruction per 3 cycles (gnt same cycle as req, rvalid next cycle, consume in HOLD).

Reset
REQ-026 Reset assertion SHALL, asynchronously and mid-transaction, force state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst=32'h0000_0013 (NOP), pcvalue=RESET_PC, inst_valid=0, fetch_misalign=0.
REQ-027 A response arriving after reset for a pre-reset request SHALL be discarded (state not WAIT).

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN defined: consumed redirect with redirect_pc[1:0]!=2'b00 SHALL set fetch_misalign=1 (sticky until reset), enter HALT, hold imem_req=0 and inst_valid=0.
REQ-029 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00, HALT unreachable, fetch_misalign tied 0.

Structure
REQ-030 Package riscv_pkg SHALL hold fetch_state_e enum, NOP_INST constant 32'h0000_0013 and the default RESET_PC.
REQ-031 One sub-module fetch_pc_reg SHALL hold fetch_pc with next-PC selection (sequential +4 / redirect / reset).

Verification
REQ-032 Reset release, gnt immediate, rvalid next cycle, rdata=32'h0050_0093, stall=0 -> imem_addr 0x0, 0x4, 0x8 on successive REQ cycles; pcvalue 0x0 with that inst.
REQ-033 stall=1 for 5 cycles in HOLD -> inst/pcvalue/inst_valid unchanged, imem_req=0 throughout.
REQ-034 Consume at pcvalue=0x10 with redirect_en=1, redirect_pc=0x100 -> next imem_addr=0x100.
REQ-035 imem_gnt low 4 cycles -> imem_req=1, imem_addr constant all 4 cycles; spurious rvalid in REQ ignored.
REQ-036 rst_n low during WAIT, rvalid after release -> inst=NOP, inst_valid=0, fetch restarts at RESET_PC.
REQ-037 redirect_pc=0x102: with FETCH_MISALIGN_TRAP_EN -> fetch_misalign=1, HALT, no further imem_req; without -> imem_addr=0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared types and constants for the instruction fetch slice.
//   fetch_state_e    : fetch FSM state encoding
//   NOP_INST         : instruction presented while nothing has been fetched
//   DEFAULT_RESET_PC : default first fetch address after reset
//   word_align()     : clears the two byte-offset bits of an address
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg -- holds the fetch program counter and selects the next one.
//   clk, rst_n   : clock, asynchronous active-low reset (loads RESET_PC)
//   load_en      : update fetch_pc this cycle (instruction consumed)
//   redirect_en  : take redirect_pc instead of the sequential address
//   redirect_pc  : redirect target (already aligned by the caller if needed)
//   cur_pc       : address of the instruction being consumed
//   fetch_pc     : current fetch address
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] cur_pc,
    output logic [31:0] fetch_pc
);

    logic [31:0] fetch_pc_d;
    logic [31:0] fetch_pc_q;

    // Sequential increment wraps naturally at 2^32.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (load_en) begin
            fetch_pc_d = redirect_en ? redirect_pc : cur_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch with a one-entry hold
// register feeding decode.
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_req/addr   : instruction memory request and word-aligned address
//   imem_gnt        : request accepted this cycle
//   imem_rvalid/rdata : read response (one or more cycles after grant)
//   inst, pcvalue, inst_valid : held instruction, its address, valid flag
//   stall           : keep the held instruction
//   redirect_en/pc  : next fetch from redirect_pc when the instruction is consumed
//   fetch_misalign  : sticky misaligned-redirect flag
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, a consumed
// redirect to a non-word-aligned target raises fetch_misalign and halts
// fetching until reset. When undefined, the target's low two bits are
// dropped and fetch_misalign is constant 0.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pcvalue,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    fetch_state_e state_d, state_q;
    logic         imem_req_d, imem_req_q;
    logic [31:0]  inst_d, inst_q;
    logic [31:0]  pcvalue_d, pcvalue_q;
    logic         inst_valid_d, inst_valid_q;

    logic [31:0]  fetch_pc;
    logic [31:0]  redirect_tgt;
    logic         consume;
    logic         redir_take;
    logic         trap;

    // Redirects only count when a valid instruction is actually consumed.
    assign consume    = (state_q == HOLD) && inst_valid_q && !stall;
    assign redir_take = consume && redirect_en;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_d, misalign_q;

    assign redirect_tgt   = redirect_pc;
    assign trap           = redir_take && (redirect_pc[1:0] != 2'b00);
    assign fetch_misalign = misalign_q;
`else
    assign redirect_tgt   = word_align(redirect_pc);
    assign trap           = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_fetch_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (consume && !trap),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_tgt),
        .cur_pc      (pcvalue_q),
        .fetch_pc    (fetch_pc)
    );

    always_comb begin
        state_d      = state_q;
        imem_req_d   = imem_req_q;
        inst_d       = inst_q;
        pcvalue_d    = pcvalue_q;
        inst_valid_d = inst_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                imem_req_d = 1'b1;
            end
            REQ: begin
                if (imem_gnt) begin
                    state_d    = WAIT;
                    imem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    inst_d       = imem_rdata;
                    pcvalue_d    = fetch_pc;
                    inst_valid_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (consume) begin
                    inst_valid_d = 1'b0;
                    if (trap) begin
                        state_d    = HALT;
                        imem_req_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        state_d    = REQ;
                        imem_req_d = 1'b1;
                    end
                end
            end
            HALT: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            imem_req_q   <= 1'b0;
            inst_q       <= NOP_INST;
            pcvalue_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            imem_req_q   <= imem_req_d;
            inst_q       <= inst_d;
            pcvalue_q    <= pcvalue_d;
            inst_valid_q <= inst_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = fetch_pc;
    assign inst       = inst_q;
    assign pcvalue    = pcvalue_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- randomized bench for fetch_unit. The bench acts as the
// instruction memory and the decode stage, and tracks the expected fetch
// stream at transaction level: next fetch address, outstanding response,
// held instruction and its address.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pcvalue;
    logic        inst_valid;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    fetch_unit #(
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .pcvalue        (pcvalue),
        .inst_valid     (inst_valid),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic [31:0] pend_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pcv;
    logic [31:0] last_fetch;
    bit          req_seen;
    bit          pending;
    bit          exp_valid;
    bit          halted;
    bit          exp_mis;
    int unsigned rv_cnt;
    int unsigned cyc;
    logic [31:0] fetch_log[$];
    int unsigned fetch_cyc[$];

    // Stimulus knobs
    int unsigned k_gnt_pct;
    int unsigned k_rv_max;
    int unsigned k_stall_pct;
    int unsigned k_redir_pct;
    bit          k_fixed;
    bit          k_spur;
    bit          k_misal_ok;
    bit          f_armed;
    bit          f_any;
    logic [31:0] f_at;
    logic [31:0] f_pc;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (k_fixed) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
    endfunction

    task automatic model_reset();
        exp_pc    = TB_RESET_PC;
        req_seen  = 1'b0;
        pending   = 1'b0;
        exp_valid = 1'b0;
        halted    = 1'b0;
        exp_mis   = 1'b0;
        rv_cnt    = 0;
    endtask

    // One clock: sample at the falling edge, then drive the next inputs.
    task automatic cycle();
        bit v_now;
        @(negedge clk);
        cyc++;
        v_now = exp_valid;
        check_eq("inst_valid", inst_valid, exp_valid);
        check_eq("fetch_misalign", fetch_misalign, exp_mis);
        if (halted) begin
            check_eq("halt_no_req", imem_req, 1'b0);
        end else if (imem_req) begin
            if (req_seen) begin
                check_eq("addr_stable", imem_addr, prev_addr);
            end else begin
                check_eq("fetch_addr", imem_addr, exp_pc);
                fetch_log.push_back(imem_addr);
                fetch_cyc.push_back(cyc);
                last_fetch = imem_addr;
            end
        end
        if (inst_valid) begin
            check_eq("inst", inst, exp_inst);
            check_eq("pcvalue", pcvalue, exp_pcv);
            check_eq("no_req_in_hold", imem_req, 1'b0);
        end
        prev_addr = imem_addr;

        // memory response
        if (pending && rv_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(pend_addr);
            exp_inst    = imem_rdata;
            exp_pcv     = pend_addr;
            exp_valid   = 1'b1;
            pending     = 1'b0;
        end else if (pending) begin
            rv_cnt--;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = k_spur ? 1'($urandom_range(1)) : 1'b0;
            imem_rdata  = $urandom;
        end

        // memory grant
        if (imem_req && !halted) begin
            imem_gnt = ($urandom_range(99) < k_gnt_pct);
            if (imem_gnt) begin
                pending   = 1'b1;
                pend_addr = imem_addr;
                rv_cnt    = $urandom_range(k_rv_max);
            end
        end else begin
            imem_gnt = k_spur ? 1'($urandom_range(1)) : 1'b0;
        end
        req_seen = imem_req && !imem_gnt;

        // decode side: junk redirect unless an instruction is consumed
        stall       = 1'($urandom_range(1));
        redirect_en = 1'($urandom_range(1));
        redirect_pc = $urandom;
        if (v_now) begin
            stall = ($urandom_range(99) < k_stall_pct);
            if (!stall) begin
                if (f_armed && (f_any || exp_pcv == f_at)) begin
                    redirect_en = 1'b1;
                    redirect_pc = f_pc;
                    f_armed     = 1'b0;
                end else begin
                    redirect_en = ($urandom_range(99) < k_redir_pct);
                    if (!k_misal_ok) redirect_pc[1:0] = 2'b00;
                end
                exp_valid = 1'b0;
                if (redirect_en) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        halted  = 1'b1;
                        exp_mis = 1'b1;
                    end else begin
                        exp_pc = redirect_pc;
                    end
`else
                    exp_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
                end else begin
                    exp_pc = exp_pcv + 32'd4;
                end
            end
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_fetches(input string tag, input int unsigned n, input int unsigned max);
        for (int unsigned i = 0; i < max && fetch_log.size() < n; i++) cycle();
        check_eq(tag, 32'(fetch_log.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, TB_RESET_PC);
        check_eq("rst_inst", inst, NOP_INST);
        check_eq("rst_pcvalue", pcvalue, TB_RESET_PC);
        check_eq("rst_valid", inst_valid, 1'b0);
        check_eq("rst_misalign", fetch_misalign, 1'b0);
        model_reset();
        // stale response and grant kept on the bus across reset release
        imem_rvalid = 1'b1;
        imem_gnt    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_req", imem_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("idle_no_req", imem_req, 1'b0);
    endtask

    initial begin
        bit          seen;
        int unsigned stuck;
        n_cmp = 0; n_err = 0; cyc = 0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        k_gnt_pct = 100; k_rv_max = 0; k_stall_pct = 0; k_redir_pct = 0;
        k_fixed = 1'b1; k_spur = 1'b0; k_misal_ok = 1'b0;
        f_armed = 1'b0; f_any = 1'b0; f_at = '0; f_pc = '0;
        exp_inst = NOP_INST; exp_pcv = TB_RESET_PC; last_fetch = '0;
        prev_addr = '0; pend_addr = '0;
        rst_n = 1'b1;
        #2;
        do_reset();

        // back-to-back fetch at full rate
        fetch_log.delete(); fetch_cyc.delete();
        wait_fetches("seq_fetches", 3, 30);
        check_eq("seq_addr0", fetch_log[0], 32'h0);
        check_eq("seq_addr1", fetch_log[1], 32'h4);
        check_eq("seq_addr2", fetch_log[2], 32'h8);
        check_eq("rate01", fetch_cyc[1] - fetch_cyc[0], 32'd3);
        check_eq("rate12", fetch_cyc[2] - fetch_cyc[1], 32'd3);

        // stall held in HOLD
        k_fixed = 1'b0;
        k_stall_pct = 100;
        seen = 1'b0;
        for (int unsigned i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = inst_valid;
        end
        check_eq("stall_reach_hold", seen, 1'b1);
        run(5);
        k_stall_pct = 0;

        // redirect on consume at 0x10
        f_armed = 1'b1; f_any = 1'b0; f_at = 32'h10; f_pc = 32'h100;
        seen = 1'b0;
        for (int unsigned i = 0; i < 60 && !seen; i++) begin
            cycle();
            seen = (last_fetch == 32'h100);
        end
        check_eq("redirect_target", last_fetch, 32'h100);

        // grant withheld, spurious responses and grants around it
        k_gnt_pct = 0; k_spur = 1'b1;
        stuck = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            cycle();
            if (imem_req) stuck++;
        end
        check_eq("gnt_wait_cycles", 32'(stuck >= 4), 32'd1);
        k_gnt_pct = 100; k_spur = 1'b0;

        // sequential wrap from the top of the address space
        f_armed = 1'b1; f_any = 1'b1; f_pc = 32'hFFFF_FFFC;
        fetch_log.delete();
        wait_fetches("wrap_fetches", 2, 40);
        check_eq("wrap_top", fetch_log[0], 32'hFFFF_FFFC);
        check_eq("wrap_zero", fetch_log[1], 32'h0);

        // reset while a response is outstanding
        seen = 1'b0;
        for (int unsigned i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = pending;
        end
        check_eq("reach_wait", seen, 1'b1);
        @(posedge clk);
        #2;
        do_reset();
        k_spur = 1'b1;
        fetch_log.delete();
        cycle();
        check_eq("post_rst_inst", inst, NOP_INST);
        check_eq("post_rst_valid", inst_valid, 1'b0);
        check_eq("post_rst_fetches", fetch_log.size(), 32'd1);
        check_eq("post_rst_pc", last_fetch, TB_RESET_PC);

        // randomized traffic
        k_gnt_pct = 60; k_rv_max = 3; k_stall_pct = 40; k_redir_pct = 25;
`ifdef FETCH_MISALIGN_TRAP_EN
        k_misal_ok = 1'b0;
`else
        k_misal_ok = 1'b1;
`endif
        fetch_log.delete();
        run(1500);
        check_eq("random_progress", 32'(fetch_log.size() > 100), 32'd1);

        // misaligned redirect target
        k_gnt_pct = 100; k_rv_max = 0; k_stall_pct = 0; k_redir_pct = 0; k_spur = 1'b0;
        f_armed = 1'b1; f_any = 1'b1; f_pc = 32'h102;
        for (int unsigned i = 0; i < 40 && f_armed; i++) cycle();
        check_eq("misalign_consumed", f_armed, 1'b0);
        fetch_log.delete();
        run(8);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("halt_flag", fetch_misalign, 1'b1);
        check_eq("halt_no_fetch", fetch_log.size(), 32'd0);
        check_eq("halt_no_valid", inst_valid, 1'b0);
`else
        check_eq("align_fetch_cnt", 32'(fetch_log.size() > 0), 32'd1);
        if (fetch_log.size() > 0) check_eq("align_target", fetch_log[0], 32'h100);
`endif

        do_reset();
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
